// File: rtl/intra_pkg.sv
//------------------------------------------------------------------------------
// intra_pkg
// Shared default sizing for the intra stall ladder and its helpers.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package intra_pkg;
    localparam int c_NSTG    = 6;
    localparam int c_SLP_CYC = 3;
    localparam int c_AWK_W   = 3;
    localparam int c_AWK_TAP = 3;
endpackage

`default_nettype wire

// File: rtl/intra_stall_shreg.sv
//------------------------------------------------------------------------------
// intra_stall_shreg
// Enable-gated shift register with async and sync clear to a fixed value.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module intra_stall_shreg #(
    parameter int               WIDTH   = 1,
    parameter int               DEPTH   = 2,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic                         clk,
    input  logic                         arst_n,
    input  logic                         i_clr,
    input  logic                         i_en,
    input  logic [WIDTH-1:0]             i_din,
    output logic [DEPTH-1:0][WIDTH-1:0]  o_q
);

    logic [DEPTH-1:0][WIDTH-1:0] r_q;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_q <= {DEPTH{RST_VAL}};
        end else if (i_clr) begin
            r_q <= {DEPTH{RST_VAL}};
        end else if (i_en) begin
            r_q[0] <= i_din;
            for (int k = 1; k < DEPTH; k++) begin
                r_q[k] <= r_q[k-1];
            end
        end
    end

    assign o_q = r_q;

endmodule

`default_nettype wire

// File: rtl/intra_stall_ladder.sv
//------------------------------------------------------------------------------
// intra_stall_ladder
// Residual-path stall generator: source request, forced sleep, staged stalls.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module intra_stall_ladder
    import intra_pkg::*;
#(
    parameter int NSTG    = c_NSTG,
    parameter int SLP_CYC = c_SLP_CYC,
    parameter int AWK_W   = c_AWK_W,
    parameter int AWK_TAP = c_AWK_TAP
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             rst_n,
    input  logic             resi_val,
    input  logic             src_val,
    output logic             src_rdy,
    input  logic             last_cyc_in_tb,
    input  logic             c_idx,
    input  logic             last32_in_64,
    input  logic             hold,
    output logic             stop_now,
    output logic [NSTG-1:0]  stop_dly,
    output logic [NSTG-1:0]  stop_lad,
    output logic [AWK_W-1:0] awk_cnt_dly,
    output logic             sleeping
);

    localparam logic [AWK_W-1:0] c_SLP = AWK_W'(SLP_CYC);

    logic                          r_primed;
    logic                          r_stop_src;
    logic                          r_sleeping;
    logic [AWK_W-1:0]              r_slp_cnt;
    logic [AWK_W-1:0]              r_awk_cnt;
    logic [NSTG-1:0]               w_d;
    logic [AWK_TAP-1:0][AWK_W-1:0] w_awk_pipe;
    logic                          w_stop_now;
    logic                          w_src_rdy;
    logic [AWK_W-1:0]              w_awk_inc;

    assign w_stop_now = !resi_val || r_stop_src || r_sleeping || hold;
    assign w_src_rdy  = resi_val &&
                        ((last_cyc_in_tb && !c_idx && !w_stop_now && last32_in_64) ||
                         (r_slp_cnt == c_SLP) || !r_primed);
    assign w_awk_inc  = (r_awk_cnt >= c_SLP) ? c_SLP : r_awk_cnt + AWK_W'(1);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_primed   <= 1'b0;
            r_stop_src <= 1'b0;
            r_sleeping <= 1'b0;
            r_slp_cnt  <= '0;
            r_awk_cnt  <= '0;
        end else if (!rst_n) begin
            r_primed   <= 1'b0;
            r_stop_src <= 1'b0;
            r_sleeping <= 1'b0;
            r_slp_cnt  <= '0;
            r_awk_cnt  <= '0;
        end else if (resi_val) begin
            r_primed   <= 1'b1;
            r_stop_src <= !src_val && w_src_rdy;
            // A stall opens a bounded sleep window; reaching the limit forces a wake
            if (w_stop_now && (r_slp_cnt < c_SLP)) begin
                r_sleeping <= 1'b1;
                r_slp_cnt  <= r_slp_cnt + AWK_W'(1);
            end else begin
                r_sleeping <= 1'b0;
                r_slp_cnt  <= '0;
            end
            if (!r_sleeping && !w_stop_now) begin
                r_awk_cnt <= w_awk_inc;
            end else begin
                r_awk_cnt <= '0;
            end
        end
    end

    intra_stall_shreg #(
        .WIDTH   (1),
        .DEPTH   (NSTG),
        .RST_VAL (1'b1)
    ) u_stop_shreg (
        .clk    (clk),
        .arst_n (arst_n),
        .i_clr  (!rst_n),
        .i_en   (resi_val),
        .i_din  (w_stop_now),
        .o_q    (w_d)
    );

    intra_stall_shreg #(
        .WIDTH   (AWK_W),
        .DEPTH   (AWK_TAP),
        .RST_VAL ('0)
    ) u_awk_shreg (
        .clk    (clk),
        .arst_n (arst_n),
        .i_clr  (!rst_n),
        .i_en   (resi_val),
        .i_din  (r_awk_cnt),
        .o_q    (w_awk_pipe)
    );

    // Ladder stage releases as soon as its upstream neighbour has released
    assign stop_lad[0] = (w_stop_now && w_d[0]) || !resi_val;
    generate
        for (genvar k = 1; k < NSTG; k++) begin : g_lad
            assign stop_lad[k] = (w_d[k-1] && w_d[k]) || !resi_val;
        end
    endgenerate

    assign stop_dly    = w_d | {NSTG{!resi_val}};
    assign stop_now    = w_stop_now;
    assign src_rdy     = w_src_rdy;
    assign sleeping    = r_sleeping;
    assign awk_cnt_dly = w_awk_pipe[AWK_TAP-1];

endmodule

`default_nettype wire

// File: tb/tb_intra_stall_ladder.sv
//------------------------------------------------------------------------------
// tb_intra_stall_ladder
// Vector table, directed corner sequences and random run against a queue model.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_intra_stall_ladder;

    localparam int NSTG    = 6;
    localparam int SLP_CYC = 3;
    localparam int AWK_W   = 3;
    localparam int AWK_TAP = 3;

    logic             clk = 1'b0;
    logic             arst_n, rst_n, resi_val, src_val, last_cyc_in_tb;
    logic             c_idx, last32_in_64, hold;
    logic             src_rdy, stop_now, sleeping;
    logic [NSTG-1:0]  stop_dly, stop_lad;
    logic [AWK_W-1:0] awk_cnt_dly;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    intra_stall_ladder #(
        .NSTG(NSTG), .SLP_CYC(SLP_CYC), .AWK_W(AWK_W), .AWK_TAP(AWK_TAP)
    ) dut (
        .clk(clk), .arst_n(arst_n), .rst_n(rst_n), .resi_val(resi_val),
        .src_val(src_val), .src_rdy(src_rdy), .last_cyc_in_tb(last_cyc_in_tb),
        .c_idx(c_idx), .last32_in_64(last32_in_64), .hold(hold),
        .stop_now(stop_now), .stop_dly(stop_dly), .stop_lad(stop_lad),
        .awk_cnt_dly(awk_cnt_dly), .sleeping(sleeping)
    );

    // Reference model: stop history and awake history kept as queues, newest first
    bit m_primed, m_stop_src, m_sleeping;
    int m_slp, m_awk;
    bit m_hist[$];
    int m_awkq[$];

    function automatic void m_reset();
        m_primed = 0; m_stop_src = 0; m_sleeping = 0; m_slp = 0; m_awk = 0;
        m_hist.delete(); m_awkq.delete();
        for (int i = 0; i < NSTG; i++) m_hist.push_back(1'b1);
        for (int i = 0; i < AWK_TAP; i++) m_awkq.push_back(0);
    endfunction

    function automatic bit m_stop_now();
        return !resi_val || m_stop_src || m_sleeping || hold;
    endfunction

    function automatic bit m_src_rdy();
        return resi_val && ((last_cyc_in_tb && !c_idx && !m_stop_now() && last32_in_64) ||
                            (m_slp == SLP_CYC) || !m_primed);
    endfunction

    function automatic void m_step();
        bit sn, sr;
        int awk_next;
        if (!rst_n) begin
            m_reset();
        end else if (resi_val) begin
            sn = m_stop_now();
            sr = m_src_rdy();
            awk_next = (!m_sleeping && !sn) ? ((m_awk + 1 > SLP_CYC) ? SLP_CYC : m_awk + 1) : 0;
            m_hist.push_front(sn);   void'(m_hist.pop_back());
            m_awkq.push_front(m_awk); void'(m_awkq.pop_back());
            m_stop_src = !src_val && sr;
            if (sn && m_slp < SLP_CYC) begin
                m_sleeping = 1; m_slp = m_slp + 1;
            end else begin
                m_sleeping = 0; m_slp = 0;
            end
            m_awk = awk_next;
            m_primed = 1;
        end
    endfunction

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    task automatic compare_model(string tag);
        logic [NSTG-1:0] edly, elad;
        bit sn;
        sn = m_stop_now();
        for (int k = 0; k < NSTG; k++) begin
            edly[k] = m_hist[k] || !resi_val;
            elad[k] = ((k == 0) ? (sn && m_hist[0]) : (m_hist[k-1] && m_hist[k])) || !resi_val;
        end
        chk({tag, ".src_rdy"},  src_rdy,     m_src_rdy());
        chk({tag, ".stop_now"}, stop_now,    sn);
        chk({tag, ".stop_dly"}, stop_dly,    edly);
        chk({tag, ".stop_lad"}, stop_lad,    elad);
        chk({tag, ".awk_dly"},  awk_cnt_dly, m_awkq[AWK_TAP-1]);
        chk({tag, ".sleeping"}, sleeping,    m_sleeping);
    endtask

    task automatic drive(input logic rv, sv, lc, ci, l32, hd, rn);
        @(negedge clk);
        resi_val = rv; src_val = sv; last_cyc_in_tb = lc; c_idx = ci;
        last32_in_64 = l32; hold = hd; rst_n = rn;
        #1;
    endtask

    task automatic advance();
        @(posedge clk);
        m_step();
    endtask

    typedef struct {
        logic             rv, sv;
        logic             e_rdy, e_now, e_slp;
        logic [NSTG-1:0]  e_dly, e_lad;
        logic [AWK_W-1:0] e_awk;
    } vec_t;

    vec_t tbl[7];
    int   awk_exp[8] = '{0, 0, 0, 0, 1, 2, 3, 3};
    bit   h_now[8]   = '{1, 1, 1, 1, 0, 0, 0, 0};
    bit   h_d2[8]    = '{0, 0, 0, 1, 1, 1, 1, 0};
    bit   h_l2[8]    = '{0, 0, 0, 1, 1, 1, 0, 0};
    bit   h_rdy[8]   = '{0, 0, 0, 1, 0, 0, 0, 0};
    bit   r_now[5]   = '{1, 1, 1, 0, 0};
    bit   r_rdy[5]   = '{0, 0, 1, 0, 0};

    initial begin
        // Starvation from reset: request, stall, three sleep cycles, re-request
        tbl[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 6'b111111, 6'b111110, 3'd0};
        tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 6'b111110, 6'b111100, 3'd0};
        tbl[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 6'b111101, 6'b111001, 3'd0};
        tbl[3] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 6'b111011, 6'b110011, 3'd0};
        tbl[4] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 6'b110111, 6'b100111, 3'd1};
        tbl[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 6'b101111, 6'b001111, 3'd0};
        tbl[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 6'b011111, 6'b011111, 3'd0};

        arst_n = 0; rst_n = 1; resi_val = 0; src_val = 0; last_cyc_in_tb = 0;
        c_idx = 0; last32_in_64 = 0; hold = 0;
        m_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        arst_n = 1;

        drive(0, 0, 0, 0, 0, 0, 1);
        compare_model("reset");
        chk("reset.stop_dly", stop_dly, {NSTG{1'b1}});
        chk("reset.awk_dly", awk_cnt_dly, 0);
        advance();

        foreach (tbl[i]) begin
            drive(tbl[i].rv, tbl[i].sv, 0, 0, 0, 0, 1);
            chk("tbl.src_rdy",  src_rdy,     tbl[i].e_rdy);
            chk("tbl.stop_now", stop_now,    tbl[i].e_now);
            chk("tbl.sleeping", sleeping,    tbl[i].e_slp);
            chk("tbl.stop_dly", stop_dly,    tbl[i].e_dly);
            chk("tbl.stop_lad", stop_lad,    tbl[i].e_lad);
            chk("tbl.awk_dly",  awk_cnt_dly, tbl[i].e_awk);
            advance();
        end

        // Steady data after a synchronous clear
        drive(1, 1, 0, 0, 0, 0, 0); compare_model("clr"); advance();
        for (int c = 0; c < 8; c++) begin
            drive(1, 1, 0, 0, 0, 0, 1);
            compare_model("steady");
            chk("steady.stop_now", stop_now, 0);
            chk("steady.awk_dly", awk_cnt_dly, awk_exp[c]);
            chk("steady.dly5", stop_dly[5], (c >= 6) ? 0 : 1);
            advance();
        end

        // Single-cycle hold
        for (int c = 0; c < 8; c++) begin
            drive(1, 1, 0, 0, 0, (c == 0), 1);
            compare_model("hold");
            chk("hold.stop_now", stop_now, h_now[c]);
            chk("hold.dly2", stop_dly[2], h_d2[c]);
            chk("hold.lad2", stop_lad[2], h_l2[c]);
            chk("hold.src_rdy", src_rdy, h_rdy[c]);
            advance();
        end

        // Freeze mid-sleep then resume
        drive(1, 1, 0, 0, 0, 1, 1); compare_model("frz"); advance();
        for (int c = 0; c < 4; c++) begin
            drive(0, 1, 0, 0, 0, 0, 1);
            compare_model("frz");
            chk("frz.sleeping", sleeping, 1);
            chk("frz.stop_lad", stop_lad, {NSTG{1'b1}});
            chk("frz.src_rdy", src_rdy, 0);
            advance();
        end
        for (int c = 0; c < 5; c++) begin
            drive(1, 1, 0, 0, 0, 0, 1);
            compare_model("resume");
            chk("resume.stop_now", stop_now, r_now[c]);
            chk("resume.src_rdy", src_rdy, r_rdy[c]);
            advance();
        end

        // Synchronous clear mid-sleep
        drive(1, 1, 0, 0, 0, 1, 1); compare_model("sclr"); advance();
        drive(1, 1, 0, 0, 0, 0, 0); compare_model("sclr"); advance();
        drive(1, 1, 0, 0, 0, 0, 1);
        compare_model("sclr");
        chk("sclr.sleeping", sleeping, 0);
        chk("sclr.stop_dly", stop_dly, {NSTG{1'b1}});
        chk("sclr.awk_dly", awk_cnt_dly, 0);
        chk("sclr.src_rdy", src_rdy, 1);
        chk("sclr.stop_now", stop_now, 0);
        advance();

        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 9) != 0, $urandom_range(0, 1), $urandom_range(0, 1),
                  $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 9) == 0,
                  $urandom_range(0, 49) != 0);
            compare_model("rand");
            advance();
        end

        // Asynchronous reset pulse between clock edges
        drive(1, 1, 0, 0, 0, 1, 1);
        compare_model("arst");
        #1 arst_n = 0;
        #1 m_reset();
        compare_model("arst");
        chk("arst.src_rdy", src_rdy, 1);
        arst_n = 1;
        advance();
        for (int n = 0; n < 10; n++) begin
            drive(1, $urandom_range(0, 1), 0, 0, 0, 0, 1);
            compare_model("post");
            advance();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/intra_stall_ladder.md
INTRA_STALL_LADDER -- requirements
Module: intra_stall_ladder

Interface
REQ-001 SHALL have parameter NSTG, default 6: number of delayed stop stages (>=2).
REQ-002 SHALL have parameter SLP_CYC, default 3: forced sleep length and awake-count saturation value.
REQ-003 SHALL have parameter AWK_W, default 3: awake-counter width (2^AWK_W > SLP_CYC).
REQ-004 SHALL have parameter AWK_TAP, default 3: pipeline depth of awk_cnt_dly.
REQ-005 SHALL have ports, one clock, reset asynchronous active-low:
 clk  in  1  clock;
 arst_n  in  1  asynchronous active-low reset;
 rst_n  in  1  synchronous active-low clear;
 resi_val  in  1  global advance enable (residual path valid);
 src_val  in  1  entropy-decoder data valid;
 src_rdy  out  1  request to entropy decoder (combinational);
 last_cyc_in_tb  in  1  last cycle of current TB;
 c_idx  in  1  chroma flag;
 last32_in_64  in  1  last 32x32 of 64x64 CU;
 hold  in  1  downstream backpressure (new);
 stop_now  out  1  current-cycle stall;
 stop_dly  out  NSTG  per-stage registered stall;
 stop_lad  out  NSTG  per-stage early-release stall;
 awk_cnt_dly  out  AWK_W  awake count delayed AWK_TAP cycles;
 sleeping  out  1  forced-sleep flag.

Function
REQ-006 SHALL advance every register only in cycles with resi_val=1; with resi_val=0 all state holds.
REQ-007 SHALL force stop_now, all stop_dly and all stop_lad bits to 1 whenever resi_val=0.
REQ-008 SHALL keep flag primed: 0 after reset, set to 1 on first cycle with resi_val=1, never cleared except by reset.
REQ-009 SHALL drive src_rdy = resi_val AND ((last_cyc_in_tb AND !c_idx AND !stop_now AND last32_in_64) OR slp_cnt==SLP_CYC OR !primed).
REQ-010 SHALL register stop_src <= (!src_val AND src_rdy) on advancing cycles.
REQ-011 SHALL drive stop_now = !resi_val OR stop_src OR sleeping OR hold.
REQ-012 SHALL, on advancing cycles: if stop_now AND slp_cnt<SLP_CYC then sleeping<=1, slp_cnt<=slp_cnt+1; else sleeping<=0, slp_cnt<=0.
REQ-013 SHALL, on advancing cycles: if !sleeping AND !stop_now then awk_cnt <= min(awk_cnt+1, SLP_CYC); else awk_cnt<=0.
REQ-014 SHALL shift d[0]<=stop_now, d[k]<=d[k-1] on advancing cycles; stop_dly[k] = d[k] OR !resi_val.
REQ-015 SHALL drive stop_lad[0] = (stop_now AND d[0]) OR !resi_val, stop_lad[k] = (d[k-1] AND d[k]) OR !resi_val: asserts with stop_dly[k], releases one cycle earlier.
REQ-016 SHALL pipe awk_cnt through AWK_TAP advancing registers to awk_cnt_dly.
REQ-017 SHALL give hold no effect on src_rdy other than via stop_now; simultaneous hold and src_rdy term is legal.

Reset
REQ-018 SHALL on arst_n=0 (async) or rst_n=0 (sync, priority over resi_val) set d[*]=1, primed=0, stop_src=0, sleeping=0, slp_cnt=0, awk_cnt=0, awk pipe=0.
REQ-019 SHALL after reset show stop_dly=all-1, awk_cnt_dly=0, sleeping=0, src_rdy=resi_val.

Structure
REQ-020 SHALL take NSTG/SLP_CYC/AWK_W defaults from shared package intra_pkg constants.
REQ-021 SHALL instantiate one sub-module intra_stall_shreg (enable-gated shift register, width and reset-value parameters), used for d[] and awk pipe.

Verification
REQ-022 SHALL test: release reset, resi_val=1, src_val=0 -> src_rdy=1 cycle0; stop_now=1 cycle1; sleeping 1 cycles2-4; src_rdy=1 when slp_cnt=3.
REQ-023 SHALL test: src_val=1 steady, no hold -> stop_now=0, awk_cnt 1,2,3,3; stop_dly[5] mirrors stop_now 6 cycles late.
REQ-024 SHALL test: resi_val=0 for 4 cycles mid-sleep -> all stop outputs 1, slp_cnt/awk/d frozen, resume same values.
REQ-025 SHALL test: 1-cycle hold at t with src_val=1 -> stop_now 1 at t..t+3; stop_dly[2] 1 at t+3..t+6; stop_lad[2] 1 at t+3..t+5.
REQ-026 SHALL test: rst_n=0 one cycle mid-sleep -> next cycle state equals REQ-018 values, primed=0, src_rdy=1.
